// File: rtl/wb_rr_arbiter_wdt.sv
// Wishbone B4 classic N-to-1 arbiter: round-robin grant held for a whole CYC burst,
// with a per-transfer ack watchdog that aborts a hung slave by raising ERR to the owner.
`timescale 1ns/1ps
module wb_rr_arbiter_wdt #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*ADDR_WIDTH-1:0] wbm_adr_i,
    input  logic [PORTS*DATA_WIDTH-1:0] wbm_dat_i,
    input  logic [PORTS*SEL_WIDTH-1:0]  wbm_sel_i,
    input  logic [PORTS-1:0]            wbm_we_i,
    input  logic [PORTS-1:0]            wbm_stb_i,
    input  logic [PORTS-1:0]            wbm_cyc_i,
    output logic [DATA_WIDTH-1:0]       wbm_dat_o,
    output logic [PORTS-1:0]            wbm_ack_o,
    output logic [PORTS-1:0]            wbm_err_o,
    output logic [PORTS-1:0]            wbm_rty_o,
    output logic [ADDR_WIDTH-1:0]       wbs_adr_o,
    output logic [DATA_WIDTH-1:0]       wbs_dat_o,
    output logic [SEL_WIDTH-1:0]        wbs_sel_o,
    output logic                        wbs_we_o,
    output logic                        wbs_stb_o,
    output logic                        wbs_cyc_o,
    input  logic [DATA_WIDTH-1:0]       wbs_dat_i,
    input  logic                        wbs_ack_i,
    input  logic                        wbs_err_i,
    input  logic                        wbs_rty_i,
    output logic [PORTS-1:0]            grant_o,
    output logic                        timeout_o
);

    localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

    state_t           state_reg;
    logic [PORTS-1:0] grant_reg;
    logic [PORTS-1:0] grant_next;
    logic [IDX_W-1:0] last_reg;
    logic [IDX_W-1:0] winner;
    logic [IDX_W:0]   cand;
    logic             found;
    logic             err_pulse_reg;
    logic             wdt_fire;

    // Unpacked views of the packed master buses, indexed by owner below.
    logic [ADDR_WIDTH-1:0] adr_arr [PORTS];
    logic [DATA_WIDTH-1:0] dat_arr [PORTS];
    logic [SEL_WIDTH-1:0]  sel_arr [PORTS];

    generate
        for (genvar gi = 0; gi < PORTS; gi++) begin : g_unpack
            assign adr_arr[gi] = wbm_adr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign dat_arr[gi] = wbm_dat_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign sel_arr[gi] = wbm_sel_i[gi*SEL_WIDTH +: SEL_WIDTH];
        end
    endgenerate

    // While BUSY/ABORT the owner is always the last winner.
    logic busy;
    logic m_cyc;
    logic slave_resp;

    assign busy       = (state_reg == BUSY);
    assign m_cyc      = wbm_cyc_i[last_reg];
    assign slave_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;

    assign wbs_cyc_o = busy & m_cyc;
    assign wbs_stb_o = busy & m_cyc & wbm_stb_i[last_reg];
    assign wbs_we_o  = busy & wbm_we_i[last_reg];
    assign wbs_adr_o = busy ? adr_arr[last_reg] : '0;
    assign wbs_dat_o = busy ? dat_arr[last_reg] : '0;
    assign wbs_sel_o = busy ? sel_arr[last_reg] : '0;

    assign wbm_dat_o = wbs_dat_i;
    assign wbm_ack_o = (busy & wbs_ack_i) ? grant_reg : '0;
    assign wbm_rty_o = (busy & wbs_rty_i) ? grant_reg : '0;
    assign wbm_err_o = ((busy & wbs_err_i) | err_pulse_reg) ? grant_reg : '0;
    assign grant_o   = grant_reg;
    assign timeout_o = err_pulse_reg;

    // Round-robin search starting just above the previous winner.
    always_comb begin
        winner = last_reg;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= PORTS; k++) begin
            cand = {1'b0, last_reg} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(PORTS))
                cand = cand - (IDX_W+1)'(PORTS);
            if (!found && wbm_cyc_i[cand[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDX_W-1:0];
            end
        end
        grant_next         = '0;
        grant_next[winner] = 1'b1;
    end

    generate
        if (TIMEOUT > 0) begin : g_wdt
            localparam int WDT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            logic [WDT_W-1:0] wdt_reg;
            logic             stalled;

            assign stalled  = wbs_stb_o & ~slave_resp;
            assign wdt_fire = stalled && (wdt_reg == WDT_W'(TIMEOUT - 1));

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    wdt_reg <= '0;
                else if (stalled && !wdt_fire)
                    wdt_reg <= wdt_reg + 1'b1;
                else
                    wdt_reg <= '0;
            end
        end else begin : g_no_wdt
            assign wdt_fire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            last_reg      <= IDX_W'(PORTS - 1);
            err_pulse_reg <= 1'b0;
        end else begin
            err_pulse_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (|wbm_cyc_i) begin
                        grant_reg <= grant_next;
                        last_reg  <= winner;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (!m_cyc) begin
                        grant_reg <= '0;
                        state_reg <= IDLE;
                    end else if (wdt_fire) begin
                        state_reg     <= ABORT;
                        err_pulse_reg <= 1'b1;
                    end
                end
                ABORT: begin
                    // Grant held so nobody else reaches the slave until the owner lets go.
                    if (!m_cyc) begin
                        grant_reg <= '0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    grant_reg <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter_wdt.sv
// Directed bench for wb_rr_arbiter_wdt: a per-cycle vector table for arbitration and
// routing, plus hand sequences for watchdog abort, response-vs-timeout race and async reset.
`timescale 1ns/1ps
module tb_wb_rr_arbiter_wdt;

    localparam int P  = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [P*AW-1:0] adr_bus;
    logic [P*DW-1:0] dat_bus;
    logic [P*SW-1:0] sel_bus;
    logic [P-1:0]    we_bus;
    logic [P-1:0]    stb;
    logic [P-1:0]    cyc;
    logic [DW-1:0]   m_dat;
    logic [P-1:0]    m_ack, m_err, m_rty;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel;
    logic            s_we, s_stb, s_cyc;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack, s_err, s_rty;
    logic [P-1:0]    grant;
    logic            tmo;

    wb_rr_arbiter_wdt #(
        .PORTS(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEL_WIDTH(SW), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .wbm_adr_i(adr_bus), .wbm_dat_i(dat_bus), .wbm_sel_i(sel_bus),
        .wbm_we_i(we_bus), .wbm_stb_i(stb), .wbm_cyc_i(cyc),
        .wbm_dat_o(m_dat), .wbm_ack_o(m_ack), .wbm_err_o(m_err), .wbm_rty_o(m_rty),
        .wbs_adr_o(s_adr), .wbs_dat_o(s_dat_o), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
        .wbs_stb_o(s_stb), .wbs_cyc_o(s_cyc),
        .wbs_dat_i(s_dat_i), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
        .grant_o(grant), .timeout_o(tmo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cyc;
        logic        sack;
        logic        serr;
        logic [31:0] sdat;
        logic [3:0]  grant;
        logic        scyc;
        logic [3:0]  ack;
        logic [3:0]  err;
        logic [31:0] adr;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] c, input logic sa, input logic se, input logic [31:0] sd,
                       input logic [3:0] g, input logic sc, input logic [3:0] a,
                       input logic [3:0] e, input logic [31:0] ad);
        vec_t v;
        v.cyc = c; v.sack = sa; v.serr = se; v.sdat = sd;
        v.grant = g; v.scyc = sc; v.ack = a; v.err = e; v.adr = ad;
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs at the falling edge and settle before sampling.
    task automatic drive(input logic [3:0] c, input logic sa, input logic se, input logic [31:0] sd);
        @(negedge clk);
        cyc = c; stb = c; s_ack = sa; s_err = se; s_dat_i = sd;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_wdat;
        logic [3:0]  exp_sel;
        logic        exp_we;

        for (int p = 0; p < P; p++) begin
            adr_bus[p*AW +: AW] = 32'hA000_0000 | (p << 4);
            dat_bus[p*DW +: DW] = (32'hA000_0000 | (p << 4)) ^ 32'h7000_0000;
            sel_bus[p*SW +: SW] = 4'(1 << p);
        end
        we_bus = 4'b1010;
        cyc = '0; stb = '0; s_ack = 0; s_err = 0; s_rty = 0; s_dat_i = '0;

        // Round-robin with all masters requesting; start from port 0 after reset.
        add(4'hF,0,0,0, 4'h0,0,4'h0,4'h0,32'h0);
        add(4'hF,1,0,0, 4'h1,1,4'h1,4'h0,32'hA000_0000);
        add(4'hE,0,0,0, 4'h1,0,4'h0,4'h0,32'hA000_0000);
        add(4'hE,0,0,0, 4'h0,0,4'h0,4'h0,32'h0);
        add(4'hE,1,0,0, 4'h2,1,4'h2,4'h0,32'hA000_0010);
        add(4'hC,0,0,0, 4'h2,0,4'h0,4'h0,32'hA000_0010);
        add(4'hC,0,0,0, 4'h0,0,4'h0,4'h0,32'h0);
        add(4'hC,1,0,0, 4'h4,1,4'h4,4'h0,32'hA000_0020);
        add(4'h8,0,0,0, 4'h4,0,4'h0,4'h0,32'hA000_0020);
        add(4'h8,0,0,0, 4'h0,0,4'h0,4'h0,32'h0);
        add(4'h8,1,0,0, 4'h8,1,4'h8,4'h0,32'hA000_0030);
        add(4'h1,0,0,0, 4'h8,0,4'h0,4'h0,32'hA000_0030);
        add(4'h1,0,0,0, 4'h0,0,4'h0,4'h0,32'h0);
        add(4'h1,1,0,0, 4'h1,1,4'h1,4'h0,32'hA000_0000);
        add(4'h0,0,0,0, 4'h1,0,4'h0,4'h0,32'hA000_0000);
        add(4'h0,0,0,0, 4'h0,0,4'h0,4'h0,32'h0);
        // Master 2 single read, slave err routing, ack with data on the third cycle.
        add(4'h4,0,0,0,            4'h0,0,4'h0,4'h0,32'h0);
        add(4'h4,0,0,0,            4'h4,1,4'h0,4'h0,32'hA000_0020);
        add(4'h4,0,1,0,            4'h4,1,4'h0,4'h4,32'hA000_0020);
        add(4'h4,1,0,32'hCAFEF00D, 4'h4,1,4'h4,4'h0,32'hA000_0020);
        add(4'h0,0,0,0,            4'h4,0,4'h0,4'h0,32'hA000_0020);
        add(4'h0,0,0,0,            4'h0,0,4'h0,4'h0,32'h0);
        // Master 1 burst of four while master 0 waits.
        add(4'h2,0,0,0,            4'h0,0,4'h0,4'h0,32'h0);
        add(4'h3,1,0,32'h1111_0001,4'h2,1,4'h2,4'h0,32'hA000_0010);
        add(4'h3,1,0,32'h1111_0002,4'h2,1,4'h2,4'h0,32'hA000_0010);
        add(4'h3,1,0,32'h1111_0003,4'h2,1,4'h2,4'h0,32'hA000_0010);
        add(4'h3,1,0,32'h1111_0004,4'h2,1,4'h2,4'h0,32'hA000_0010);
        add(4'h1,0,0,0,            4'h2,0,4'h0,4'h0,32'hA000_0010);
        add(4'h1,0,0,0,            4'h0,0,4'h0,4'h0,32'h0);
        add(4'h1,1,0,0,            4'h1,1,4'h1,4'h0,32'hA000_0000);
        add(4'h0,0,0,0,            4'h1,0,4'h0,4'h0,32'hA000_0000);
        add(4'h0,0,0,0,            4'h0,0,4'h0,4'h0,32'h0);

        // Reset held with no requests, outputs must stay quiet.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", grant, 4'h0);
        chk("rst_scyc", s_cyc, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(4'h0, i[0], 1'b0, 32'h0);
            chk("idle_grant", grant, 4'h0);
            chk("idle_scyc", s_cyc, 1'b0);
            chk("idle_ack", m_ack, 4'h0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            drive(v.cyc, v.sack, v.serr, v.sdat);
            exp_wdat = (v.adr != 0) ? (v.adr ^ 32'h7000_0000) : 32'h0;
            exp_sel  = (v.adr != 0) ? 4'(1 << v.adr[5:4]) : 4'h0;
            exp_we   = (v.adr != 0) && v.adr[4];
            chk($sformatf("v%0d_grant", i), grant, v.grant);
            chk($sformatf("v%0d_scyc", i), s_cyc, v.scyc);
            chk($sformatf("v%0d_sstb", i), s_stb, v.scyc);
            chk($sformatf("v%0d_ack", i), m_ack, v.ack);
            chk($sformatf("v%0d_err", i), m_err, v.err);
            chk($sformatf("v%0d_adr", i), s_adr, v.adr);
            chk($sformatf("v%0d_wdat", i), s_dat_o, exp_wdat);
            chk($sformatf("v%0d_sel", i), s_sel, exp_sel);
            chk($sformatf("v%0d_we", i), s_we, exp_we);
            chk($sformatf("v%0d_rdat", i), m_dat, v.sdat);
        end

        // Watchdog: master 3 stalls for exactly eight strobe cycles, then ABORT.
        drive(4'h8, 0, 0, 0);
        chk("wd_idle_grant", grant, 4'h0);
        for (int i = 0; i < 8; i++) begin
            drive(4'h8, 0, 0, 0);
            chk($sformatf("wd_stall%0d_stb", i), s_stb, 1'b1);
            chk($sformatf("wd_stall%0d_err", i), m_err, 4'h0);
            chk($sformatf("wd_stall%0d_tmo", i), tmo, 1'b0);
        end
        drive(4'hA, 0, 0, 0);
        chk("wd_abort_err", m_err, 4'h8);
        chk("wd_abort_tmo", tmo, 1'b1);
        chk("wd_abort_scyc", s_cyc, 1'b0);
        chk("wd_abort_sstb", s_stb, 1'b0);
        chk("wd_abort_grant", grant, 4'h8);
        drive(4'hA, 1, 0, 0);
        chk("wd_hold_err", m_err, 4'h0);
        chk("wd_hold_tmo", tmo, 1'b0);
        chk("wd_late_ack", m_ack, 4'h0);
        chk("wd_hold_grant", grant, 4'h8);
        drive(4'h2, 0, 0, 0);
        chk("wd_release_grant", grant, 4'h8);
        drive(4'h2, 0, 0, 0);
        chk("wd_gap_grant", grant, 4'h0);

        // Slave response on the would-fire cycle wins over the watchdog.
        for (int i = 0; i < 7; i++) begin
            drive(4'h2, 0, 0, 0);
            chk($sformatf("race%0d_grant", i), grant, 4'h2);
        end
        drive(4'h2, 1, 0, 0);
        chk("race_ack", m_ack, 4'h2);
        chk("race_err", m_err, 4'h0);
        drive(4'h2, 0, 0, 0);
        chk("race_no_tmo", tmo, 1'b0);
        chk("race_no_err", m_err, 4'h0);
        chk("race_still_busy", s_cyc, 1'b1);
        drive(4'h0, 0, 0, 0);
        drive(4'h0, 0, 0, 0);
        chk("race_idle", grant, 4'h0);

        // Asynchronous reset mid-burst, then arbitration restarts at port 0.
        drive(4'h4, 0, 0, 0);
        drive(4'h4, 1, 0, 0);
        chk("mid_ack", m_ack, 4'h4);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_grant", grant, 4'h0);
        chk("arst_scyc", s_cyc, 1'b0);
        chk("arst_sstb", s_stb, 1'b0);
        chk("arst_ack", m_ack, 4'h0);
        chk("arst_adr", s_adr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc = 4'h9; stb = 4'h9; s_ack = 0;
        drive(4'h9, 0, 0, 0);
        chk("restart_grant", grant, 4'h1);
        chk("restart_adr", s_adr, 32'hA000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
